// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the sequential ALU (alu_seq).
//   * 5-bit opcode constants
//   * PSR bit indices; psr is {Z,C,F,N,L} on bits [4:0]
//   * FSM state encoding and the iterative-unit operating modes
// Build option: define ALU_MUL_EN to add the MUL opcode (0x10) and its MUL state.
package alu_pkg;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_AND  = 5'h01;
  localparam logic [4:0] OP_OR   = 5'h02;
  localparam logic [4:0] OP_XOR  = 5'h03;
  localparam logic [4:0] OP_NOT  = 5'h04;
  localparam logic [4:0] OP_ADD  = 5'h05;
  localparam logic [4:0] OP_ADDU = 5'h06;
  localparam logic [4:0] OP_ADDC = 5'h07;
  localparam logic [4:0] OP_ADDCU= 5'h08;
  localparam logic [4:0] OP_SUB  = 5'h09;
  localparam logic [4:0] OP_SUBC = 5'h0A;
  localparam logic [4:0] OP_CMP  = 5'h0B;
  localparam logic [4:0] OP_LSH  = 5'h0C;
  localparam logic [4:0] OP_RSH  = 5'h0D;
  localparam logic [4:0] OP_ARSH = 5'h0E;
  localparam logic [4:0] OP_CMPU = 5'h0F;
  localparam logic [4:0] OP_MUL  = 5'h10;

  localparam int PSR_W = 5;
  localparam int PSR_Z = 4;
  localparam int PSR_C = 3;
  localparam int PSR_F = 2;
  localparam int PSR_N = 1;
  localparam int PSR_L = 0;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MUL, ST_HOLD} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_HOLD} state_e;
`endif

  typedef enum logic [1:0] {IT_LSH, IT_RSH, IT_ARSH, IT_MUL} iter_mode_e;

endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit -- multi-cycle datapath for variable shifts (and MUL when ALU_MUL_EN).
//   start     in   load operands, mode and step count
//   mode      in   IT_LSH / IT_RSH / IT_ARSH / IT_MUL
//   a         in   shift source, or multiplicand for MUL
//   b         in   multiplier for MUL (present only with ALU_MUL_EN)
//   cnt_init  in   number of steps to run (shift amount, or WIDTH for MUL)
//   run       in   advance one step this cycle
//   last      out  the step taken this cycle is the final one
//   value     out  value after this cycle's step (low half of product for MUL)
//   cout      out  carry for PSR.C after this step: bit shifted out, or high-half!=0 for MUL
// Outputs are combinational from the current step so the top can register the final
// result on the same edge that completes the operation.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int CNT_W   = SHAMT_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  iter_mode_e       mode,
  input  logic [WIDTH-1:0] a,
`ifdef ALU_MUL_EN
  input  logic [WIDTH-1:0] b,
`endif
  input  logic [CNT_W-1:0] cnt_init,
  input  logic             run,
  output logic             last,
  output logic [WIDTH-1:0] value,
  output logic             cout
);

  iter_mode_e       mode_q;
  logic [WIDTH-1:0] sh_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] nxt_sh;
  logic             nxt_cout;

`ifdef ALU_MUL_EN
  // Shift-add multiply: {hi_q, sh_q} holds the growing product, sh_q starts as the
  // multiplier and is consumed LSB first.
  logic [WIDTH-1:0] mc_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH:0]   acc;
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    nxt_sh   = sh_q;
    nxt_cout = 1'b0;
`ifdef ALU_MUL_EN
    nxt_hi   = hi_q;
    acc      = '0;
`endif
    case (mode_q)
      IT_LSH: begin
        nxt_sh   = {sh_q[WIDTH-2:0], 1'b0};
        nxt_cout = sh_q[WIDTH-1];
      end
      IT_RSH: begin
        nxt_sh   = {1'b0, sh_q[WIDTH-1:1]};
        nxt_cout = sh_q[0];
      end
      IT_ARSH: begin
        nxt_sh   = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
        nxt_cout = sh_q[0];
      end
`ifdef ALU_MUL_EN
      IT_MUL: begin
        acc      = {1'b0, hi_q} + (sh_q[0] ? {1'b0, mc_q} : '0);
        nxt_hi   = acc[WIDTH:1];
        nxt_sh   = {acc[0], sh_q[WIDTH-1:1]};
        nxt_cout = (acc[WIDTH:1] != '0);
      end
`endif
      default: ;
    endcase
  end

  assign last  = (cnt_q == CNT_W'(1));
  assign value = nxt_sh;
  assign cout  = nxt_cout;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= IT_LSH;
      sh_q   <= '0;
      cnt_q  <= '0;
`ifdef ALU_MUL_EN
      mc_q   <= '0;
      hi_q   <= '0;
`endif
    end else if (start) begin
      mode_q <= mode;
      cnt_q  <= cnt_init;
`ifdef ALU_MUL_EN
      sh_q   <= (mode == IT_MUL) ? b : a;
      mc_q   <= a;
      hi_q   <= '0;
`else
      sh_q   <= a;
`endif
    end else if (run) begin
      sh_q  <= nxt_sh;
      cnt_q <= cnt_q - CNT_W'(1);
`ifdef ALU_MUL_EN
      hi_q  <= nxt_hi;
`endif
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq -- handshaked sequential ALU with registered result and status register.
//   clk, reset_n        clock; asynchronous active-low reset
//   in_valid/in_ready   operation handshake; a, b, op captured on in_valid & in_ready
//   op, a, b            opcode and operands
//   out_valid/out_ready result handshake; result and psr held while out_ready is low
//   result              registered result
//   psr                 registered {Z,C,F,N,L}
//   busy                high while a multi-cycle shift (or multiply) is running
// Build option: ALU_MUL_EN enables op 0x10 (MUL, WIDTH+1 cycle latency); otherwise
// 0x10 is a NOP and no multiplier is built.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [PSR_W-1:0] psr,
  output logic             busy
);

  localparam int CNT_W = SHAMT_W + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q;
  logic [PSR_W-1:0] psr_q;
  logic             load_alu, load_iter;

  logic             accept;
  logic [SHAMT_W-1:0] shamt;
  logic             is_shift, start_shift, start_mul;
  iter_mode_e       it_mode;
  logic [CNT_W-1:0] it_cnt_init;
  logic             it_last, it_cout;
  logic [WIDTH-1:0] it_value;
  logic [PSR_W-1:0] iter_psr;

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
  assign out_valid = (state_q == ST_HOLD);
`ifdef ALU_MUL_EN
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_MUL);
`else
  assign busy      = (state_q == ST_SHIFT);
`endif
  assign result    = res_q;
  assign psr       = psr_q;

  assign accept      = in_valid && in_ready;
  assign shamt       = b[SHAMT_W-1:0];
  assign is_shift    = (op == OP_LSH) || (op == OP_RSH) || (op == OP_ARSH);
  // A zero-amount shift has nothing to iterate; it completes through the 1-cycle path.
  assign start_shift = accept && is_shift && (shamt != '0);
`ifdef ALU_MUL_EN
  assign start_mul   = accept && (op == OP_MUL);
  assign it_cnt_init = start_mul ? CNT_W'(WIDTH) : {1'b0, shamt};
`else
  assign start_mul   = 1'b0;
  assign it_cnt_init = {1'b0, shamt};
`endif

  always_comb begin
    case (op)
      OP_LSH:  it_mode = IT_LSH;
      OP_RSH:  it_mode = IT_RSH;
      OP_ARSH: it_mode = IT_ARSH;
      default: it_mode = IT_MUL;
    endcase
  end

  alu_iter_unit #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W),
    .CNT_W   (CNT_W)
  ) u_iter (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start_shift || start_mul),
    .mode     (it_mode),
    .a        (a),
`ifdef ALU_MUL_EN
    .b        (b),
`endif
    .cnt_init (it_cnt_init),
    .run      (busy),
    .last     (it_last),
    .value    (it_value),
    .cout     (it_cout)
  );

  always_comb begin
    iter_psr        = '0;
    iter_psr[PSR_Z] = (it_value == '0);
    iter_psr[PSR_C] = it_cout;
  end

  // ---------------- single-cycle operations ----------------
  logic             cin;
  logic [WIDTH:0]   sum, diff;
  logic             add_ovf, sub_ovf;
  logic [WIDTH-1:0] alu_res;
  logic [PSR_W-1:0] alu_psr;
  logic             keep_psr, z_is_eq, fc, ff, fn, fl;

  assign cin  = psr_q[PSR_C] && ((op == OP_ADDC) || (op == OP_ADDCU) || (op == OP_SUBC));
  assign sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  // Bit WIDTH of the difference is the borrow, i.e. a < b + cin unsigned.
  assign diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    alu_res  = '0;
    keep_psr = 1'b0;
    z_is_eq  = 1'b0;
    fc       = 1'b0;
    ff       = 1'b0;
    fn       = 1'b0;
    fl       = 1'b0;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOT:  alu_res = ~a;
      OP_ADD, OP_ADDC: begin
        alu_res = sum[WIDTH-1:0];
        fc      = sum[WIDTH];
        ff      = add_ovf;
      end
      OP_ADDU, OP_ADDCU: begin
        alu_res = sum[WIDTH-1:0];
        fc      = sum[WIDTH];
      end
      OP_SUB, OP_SUBC: begin
        alu_res = diff[WIDTH-1:0];
        fc      = diff[WIDTH];
        ff      = sub_ovf;
      end
      OP_CMP: begin
        z_is_eq = 1'b1;
        fn      = $signed(a) < $signed(b);
        fl      = a < b;
      end
      OP_CMPU: begin
        z_is_eq = 1'b1;
        fl      = a < b;
      end
      OP_LSH, OP_RSH, OP_ARSH: alu_res = a;  // only reached with shamt == 0
      default: keep_psr = 1'b1;              // NOP and undefined codes
    endcase
    if (keep_psr) begin
      alu_psr = psr_q;
    end else begin
      alu_psr        = '0;
      alu_psr[PSR_Z] = z_is_eq ? (a == b) : (alu_res == '0);
      alu_psr[PSR_C] = fc;
      alu_psr[PSR_F] = ff;
      alu_psr[PSR_N] = fn;
      alu_psr[PSR_L] = fl;
    end
  end

  // ---------------- control FSM ----------------
  always_comb begin
    state_d   = state_q;
    load_alu  = 1'b0;
    load_iter = 1'b0;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          if (start_shift) begin
            state_d = ST_SHIFT;
          end else if (start_mul) begin
`ifdef ALU_MUL_EN
            state_d = ST_MUL;
`endif
          end else begin
            state_d  = ST_HOLD;
            load_alu = 1'b1;
          end
        end else if (state_q == ST_HOLD && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (it_last) begin
          state_d   = ST_HOLD;
          load_iter = 1'b1;
        end
      end
`ifdef ALU_MUL_EN
      ST_MUL: begin
        if (it_last) begin
          state_d   = ST_HOLD;
          load_iter = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      psr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_alu) begin
        res_q <= alu_res;
        psr_q <= alu_psr;
      end else if (load_iter) begin
        res_q <= it_value;
        psr_q <= iter_psr;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH=16): directed vectors plus
// randomized ops checked against an arithmetic reference model. Honours ALU_MUL_EN.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [4:0]   op_i = '0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [4:0]   psr;
  logic         busy;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op_i),
    .a         (a_i),
    .b         (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .psr       (psr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   psr;
    int           lat;
  } exp_t;

  // Reference: flags from plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [4:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [4:0] p);
    exp_t   e;
    longint ua, ub, sa, sb, s, smin, smax;
    int     sh;
    bit     cin, c, f, n, l, keep, zeq;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    smin = -(longint'(1) << (W-1));
    smax = (longint'(1) << (W-1)) - 1;
    cin  = p[3] && (o == OP_ADDC || o == OP_ADDCU || o == OP_SUBC);
    sh   = int'(ub % W);
    e.res = '0; e.lat = 1;
    c = 0; f = 0; n = 0; l = 0; keep = 0; zeq = 0;
    case (o)
      OP_AND: e.res = a & b;
      OP_OR:  e.res = a | b;
      OP_XOR: e.res = a ^ b;
      OP_NOT: e.res = ~a;
      OP_ADD, OP_ADDU, OP_ADDC, OP_ADDCU: begin
        s = ua + ub + longint'(cin);
        e.res = W'(s);
        c = (s >> W) != 0;
        if (o == OP_ADD || o == OP_ADDC) begin
          s = sa + sb + longint'(cin);
          f = (s < smin) || (s > smax);
        end
      end
      OP_SUB, OP_SUBC: begin
        s = ua - ub - longint'(cin);
        e.res = W'(s);
        c = ua < ub + longint'(cin);
        s = sa - sb - longint'(cin);
        f = (s < smin) || (s > smax);
      end
      OP_CMP:  begin zeq = 1; n = sa < sb; l = ua < ub; end
      OP_CMPU: begin zeq = 1; l = ua < ub; end
      OP_LSH: begin
        e.res = W'(ua << sh);
        if (sh != 0) c = ((ua >> (W - sh)) & 1) != 0;
        e.lat = sh + 1;
      end
      OP_RSH: begin
        e.res = W'(ua >> sh);
        if (sh != 0) c = ((ua >> (sh - 1)) & 1) != 0;
        e.lat = sh + 1;
      end
      OP_ARSH: begin
        e.res = W'(sa >>> sh);
        if (sh != 0) c = ((sa >>> (sh - 1)) & 1) != 0;
        e.lat = sh + 1;
      end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        s = ua * ub;
        e.res = W'(s);
        c = (s >> W) != 0;
        e.lat = W + 1;
      end
`endif
      default: keep = 1;
    endcase
    if (keep) e.psr = p;
    else      e.psr = {(zeq ? (a == b) : (e.res == '0)), c, f, n, l};
    return e;
  endfunction

  logic [4:0] exp_psr = '0;
  bit         pending = 0;

  // Offer one op (back-to-back with out_ready if a result is pending), wait for its
  // result, check it, then keep out_ready low for 'stall' cycles. Called at a negedge.
  task automatic run_op(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall);
    exp_t e;
    int   lat, bcnt;
    e = model(o, a, b, exp_psr);
    op_i = o; a_i = a; b_i = b; in_valid = 1'b1; out_ready = pending;
    #1;
    check("in_ready_offer", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0; pending = 0;
    op_i = 5'($urandom); a_i = W'($urandom); b_i = W'($urandom);
    @(negedge clk);
    lat = 1; bcnt = 0;
    while (!out_valid && lat < 3*W) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, e.lat);
    check("busy_cycles", bcnt, e.lat - 1);
    check("result", result, e.res);
    check("psr", psr, e.psr);
    exp_psr = e.psr;
    pending = 1;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      check("stall_result", result, e.res);
      check("stall_valid", out_valid, 1'b1);
      check("stall_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    pending = 0;
    @(negedge clk);
    check("release_valid", out_valid, 1'b0);
    check("release_ready", in_ready, 1'b1);
  endtask

  initial begin
    logic [4:0]   ro;
    logic [W-1:0] ra, rb;

    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_result", result, '0);
    check("rst_psr", psr, '0);
    reset_n = 1'b1;
    @(negedge clk);

    // Carry chain through PSR.C.
    run_op(OP_ADDU, 16'hFFFF, 16'h0001, 0);
    check("addu_res", result, 16'h0000);
    check("addu_psr", psr, 5'b11000);
    run_op(OP_ADDC, 16'h0000, 16'h0000, 0);
    check("addc_res", result, 16'h0001);
    check("addc_psr", psr, 5'b00000);
    // Signed overflow.
    run_op(OP_ADD, 16'h7FFF, 16'h0001, 0);
    check("add_ovf_res", result, 16'h8000);
    check("add_ovf_psr", psr, 5'b00100);
    run_op(OP_SUB, 16'h8000, 16'h0001, 0);
    check("sub_ovf_res", result, 16'h7FFF);
    check("sub_ovf_psr", psr, 5'b00100);
    // Compares.
    run_op(OP_CMP, 16'hFFFF, 16'h0001, 0);
    check("cmp_res", result, 16'h0000);
    check("cmp_psr", psr, 5'b00010);
    run_op(OP_CMPU, 16'hFFFF, 16'h0001, 0);
    check("cmpu_psr", psr, 5'b00000);
    // Iterative arithmetic shift: 4-cycle latency checked via the model.
    run_op(OP_ARSH, 16'h8000, 16'h0003, 0);
    check("arsh_res", result, 16'hF000);
    check("arsh_psr", psr, 5'b00000);
    // Output stall, then back-to-back accept on release.
    run_op(OP_ADD, 16'h1234, 16'h1111, 5);
    check("stall_add_res", result, 16'h2345);
    // Maximum shift: WIDTH-1 bits, completes in WIDTH cycles.
    run_op(OP_LSH, 16'h0003, 16'h000F, 0);
    check("lsh15_res", result, 16'h8000);
    check("lsh15_psr", psr, 5'b01000);
    run_op(OP_RSH, 16'h8000, 16'h000F, 0);
    check("rsh15_res", result, 16'h0001);
    release_out();

    // Reset during an LSH of 10 aborts it.
    run_op(OP_ADDU, 16'hFFFF, 16'h0001, 0);
    release_out();
    op_i = OP_LSH; a_i = 16'h00FF; b_i = 16'h000A; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_shift_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_psr", psr, '0);
    check("abort_result", result, '0);
    check("abort_ready", in_ready, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    exp_psr = '0;
    pending = 0;
    repeat (W + 2) @(negedge clk);
    check("abort_no_result", out_valid, 1'b0);

`ifdef ALU_MUL_EN
    run_op(OP_MUL, 16'h0100, 16'h0100, 0);
    check("mul_res", result, 16'h0000);
    check("mul_psr", psr, 5'b11000);
    run_op(OP_MUL, 16'h00FF, 16'h0101, 0);
    release_out();
`endif

    // Randomized ops against the model, with random stalls and releases.
    for (int i = 0; i < 300; i++) begin
      ro = 5'($urandom_range(0, 31));
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 3) == 0) ra = '1;
      if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 2));
      run_op(ro, ra, rb, $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) release_out();
    end
    if (pending) release_out();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
